// File: rtl/button_press_counter.sv
// ---------------------------------------------------------------------------
// button_press_counter
//
// Reads a mechanical pushbutton, synchronises and debounces it, and emits
// single-cycle press/release strobes. Debounced presses are counted in an
// 8-bit wrapping counter that drives the LED bank.
//
// Optional feature (define the macro to enable):
//   BUTTON_PRESS_COUNTER_AUTOREPEAT_EN - while the button stays pressed, emit
//   an extra PRESS (and count increment) REPEAT_DELAY cycles after the initial
//   press and then every REPEAT_PERIOD cycles.
//
// Ports:
//   i_clk       - system clock, sole clock
//   i_rst_n     - asynchronous active-low reset
//   i_btn       - raw asynchronous button pin
//   i_clr       - synchronous clear of the press count
//   o_btn_level - debounced level, 1 = pressed
//   o_press     - one-cycle strobe per accepted press (and per auto-repeat)
//   o_release   - one-cycle strobe per accepted release
//   o_leds      - press count, bit 7 drives LED7
// ---------------------------------------------------------------------------
module button_press_counter #(
    parameter int unsigned DB_CYCLES       = 240000,
    parameter bit          BTN_ACTIVE_HIGH = 1'b1,
    parameter int unsigned REPEAT_DELAY    = 6000000,
    parameter int unsigned REPEAT_PERIOD   = 1200000
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_btn,
    input  logic       i_clr,
    output logic       o_btn_level,
    output logic       o_press,
    output logic       o_release,
    output logic [7:0] o_leds
);

    localparam int unsigned TW = (DB_CYCLES > 2) ? $clog2(DB_CYCLES) : 1;
    localparam logic [TW-1:0] TMax = TW'(DB_CYCLES - 1);

    typedef enum logic [1:0] {
        StReleased,
        StArmPress,
        StPressed,
        StArmRelease
    } state_t;

    // Synchroniser; both flops idle at the not-pressed pin level.
    logic r_sync1, r_sync2;
    logic w_p;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync1 <= ~BTN_ACTIVE_HIGH;
            r_sync2 <= ~BTN_ACTIVE_HIGH;
        end else begin
            r_sync1 <= i_btn;
            r_sync2 <= r_sync1;
        end
    end

    assign w_p = BTN_ACTIVE_HIGH ? r_sync2 : ~r_sync2;

    state_t          r_state, w_state_next;
    logic [TW-1:0]   r_timer, w_timer_next;
    logic            r_level, w_level_next;
    logic            r_press, w_press_next;
    logic            r_release, w_release_next;
    logic [7:0]      r_count, w_count_next;
    logic            w_rep_hit;

`ifdef BUTTON_PRESS_COUNTER_AUTOREPEAT_EN
    localparam int unsigned RepMax = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY
                                                                      : REPEAT_PERIOD;
    localparam int unsigned RW = (RepMax > 2) ? $clog2(RepMax) : 1;

    logic [RW-1:0] r_rep_timer, w_rep_timer_next;
    // Set until the first repeat fires; selects the longer initial delay.
    logic          r_rep_first, w_rep_first_next;
    logic [RW-1:0] w_rep_target;

    assign w_rep_target = r_rep_first ? RW'(REPEAT_DELAY - 1) : RW'(REPEAT_PERIOD - 1);
    assign w_rep_hit    = (r_state == StPressed) && w_p && (r_rep_timer == w_rep_target);

    always_comb begin
        w_rep_timer_next = r_rep_timer;
        w_rep_first_next = r_rep_first;
        if (w_state_next == StReleased) begin
            w_rep_timer_next = '0;
            w_rep_first_next = 1'b1;
        end else if (r_state == StArmPress && w_state_next == StPressed) begin
            w_rep_timer_next = '0;
            w_rep_first_next = 1'b1;
        end else if (r_state == StPressed && w_p) begin
            if (w_rep_hit) begin
                w_rep_timer_next = '0;
                w_rep_first_next = 1'b0;
            end else begin
                w_rep_timer_next = r_rep_timer + RW'(1);
            end
        end
        // ARM_RELEASE and the PRESSED->ARM_RELEASE edge hold the timer frozen.
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rep_timer <= '0;
            r_rep_first <= 1'b1;
        end else begin
            r_rep_timer <= w_rep_timer_next;
            r_rep_first <= w_rep_first_next;
        end
    end
`else
    assign w_rep_hit = 1'b0;
`endif

    always_comb begin
        w_state_next   = r_state;
        w_timer_next   = r_timer;
        w_press_next   = 1'b0;
        w_release_next = 1'b0;
        unique case (r_state)
            StReleased: begin
                if (w_p) begin
                    w_state_next = StArmPress;
                    w_timer_next = '0;
                end
            end
            StArmPress: begin
                if (!w_p) begin
                    w_state_next = StReleased;
                end else if (r_timer == TMax) begin
                    w_state_next = StPressed;
                    w_press_next = 1'b1;
                end else begin
                    w_timer_next = r_timer + TW'(1);
                end
            end
            StPressed: begin
                if (!w_p) begin
                    w_state_next = StArmRelease;
                    w_timer_next = '0;
                end else if (w_rep_hit) begin
                    w_press_next = 1'b1;
                end
            end
            StArmRelease: begin
                if (w_p) begin
                    w_state_next = StPressed;
                end else if (r_timer == TMax) begin
                    w_state_next   = StReleased;
                    w_release_next = 1'b1;
                end else begin
                    w_timer_next = r_timer + TW'(1);
                end
            end
            default: begin
                w_state_next = StReleased;
                w_timer_next = '0;
            end
        endcase

        w_level_next = (w_state_next == StPressed) || (w_state_next == StArmRelease);

        // Clear wins over a simultaneous increment.
        if (i_clr) begin
            w_count_next = '0;
        end else if (w_press_next) begin
            w_count_next = r_count + 8'd1;
        end else begin
            w_count_next = r_count;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state   <= StReleased;
            r_timer   <= '0;
            r_level   <= 1'b0;
            r_press   <= 1'b0;
            r_release <= 1'b0;
            r_count   <= '0;
        end else begin
            r_state   <= w_state_next;
            r_timer   <= w_timer_next;
            r_level   <= w_level_next;
            r_press   <= w_press_next;
            r_release <= w_release_next;
            r_count   <= w_count_next;
        end
    end

    assign o_btn_level = r_level;
    assign o_press     = r_press;
    assign o_release   = r_release;
    assign o_leds      = r_count;

endmodule
